// File: rtl/des_key_sched_ctrl_if.sv
// DES key schedule handshake bundle.
// decrypt exists only when DES_DECRYPT_EN is defined.
interface des_key_sched_ctrl_if;
  logic        start;
  logic [55:0] key;
`ifdef DES_DECRYPT_EN
  logic        decrypt;
`endif
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

`ifdef DES_DECRYPT_EN
  modport master (
    output start, key, decrypt, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );
  modport slave (
    input  start, key, decrypt, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
`else
  modport master (
    output start, key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done
  );
  modport slave (
    input  start, key, subkey_ready,
    output subkey, subkey_valid, round, busy, done
  );
`endif
endinterface

// File: rtl/des_key_sched_ctrl.sv
// DES 16-round key schedule with valid/ready subkey stream.
// DES_DECRYPT_EN adds the reversed (decrypt) round order.
module des_key_sched_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  des_key_sched_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state;
  state_t      state_nx;
  logic [27:0] c_q;
  logic [27:0] c_nx;
  logic [27:0] d_q;
  logic [27:0] d_nx;
  logic [3:0]  rnd_q;
  logic [3:0]  rnd_nx;
  logic [3:0]  rnd_inc;
  logic        dec_q;
  logic        dec_nx;
  logic        dec_in;
  logic        valid;
  logic        xfer;
  logic [55:0] cd;
  logic [47:0] sk;

`ifdef DES_DECRYPT_EN
  assign dec_in = bus.decrypt;
`else
  assign dec_in = 1'b0;
`endif

  // Rotation amount applied when entering round r.
  function automatic logic [1:0] shift_amt(
    input logic [3:0] r,
    input logic       dec
  );
    if (dec && r == 4'd0)
      return 2'd0;
    if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15)
      return 2'd1;
    return 2'd2;
  endfunction

  // Encrypt rotates left, decrypt rotates right.
  function automatic logic [27:0] rot(
    input logic [27:0] h,
    input logic [1:0]  n,
    input logic        dec
  );
    logic [27:0] r;
    r = h;
    case (n)
      2'd1: r = dec ? {h[0], h[27:1]} : {h[26:0], h[27]};
      2'd2: r = dec ? {h[1:0], h[27:2]} : {h[25:0], h[27:26]};
      default: r = h;
    endcase
    return r;
  endfunction

  assign valid   = (state == RUN);
  assign xfer    = valid && bus.subkey_ready;
  assign rnd_inc = rnd_q + 4'd1;

  // State and schedule registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c_q   <= '0;
      d_q   <= '0;
      rnd_q <= '0;
      dec_q <= 1'b0;
    end else begin
      state <= state_nx;
      c_q   <= c_nx;
      d_q   <= d_nx;
      rnd_q <= rnd_nx;
      dec_q <= dec_nx;
    end
  end

  // Next state: load on start, advance one round per transfer.
  always_comb begin
    state_nx = state;
    c_nx     = c_q;
    d_nx     = d_q;
    rnd_nx   = rnd_q;
    dec_nx   = dec_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          c_nx     = rot(bus.key[55:28],
                         shift_amt(4'd0, dec_in), dec_in);
          d_nx     = rot(bus.key[27:0],
                         shift_amt(4'd0, dec_in), dec_in);
          rnd_nx   = 4'd0;
          dec_nx   = dec_in;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (rnd_q == 4'd15) begin
            state_nx = DONE;
          end else begin
            rnd_nx = rnd_inc;
            c_nx   = rot(c_q, shift_amt(rnd_inc, dec_q), dec_q);
            d_nx   = rot(d_q, shift_amt(rnd_inc, dec_q), dec_q);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign cd = {c_q, d_q};

  // PC-2 compression; output bit 1 is the MSB of subkey.
  always_comb begin
    sk = '0;
    for (int i = 0; i < 48; i++)
      sk[47-i] = cd[56-PC2[i]];
  end

  assign bus.subkey       = sk;
  assign bus.subkey_valid = valid;
  assign bus.round        = rnd_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Randomized bench for des_key_sched_ctrl against a schedule model.
// Decrypt cases run when DES_DECRYPT_EN is defined.
module tb_des_key_sched_ctrl;

  localparam logic [55:0] KREF = 56'hF0CCAAF556678F;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int ENC_SH [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  des_key_sched_ctrl_if bus ();

  des_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] rotl(input logic [27:0] h, input int n);
    int m;
    m = n % 28;
    return (h << m) | (h >> (28 - m));
  endfunction

  function automatic logic [47:0] pc2f(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++)
      k[47-i] = cd[56-PC2[i]];
    return k;
  endfunction

  // Encrypt subkey r = PC-2 of key halves rotated left by the
  // cumulative shift; decrypt order is encrypt order reversed.
  function automatic logic [47:0] exp_sub(
    input logic [55:0] k,
    input logic        dec,
    input int          r
  );
    int idx;
    int tot;
    idx = dec ? 15 - r : r;
    tot = 0;
    for (int i = 0; i <= idx; i++)
      tot += ENC_SH[i];
    return pc2f({rotl(k[55:28], tot), rotl(k[27:0], tot)});
  endfunction

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 run, 2 done.
  int          m_phase;
  int          m_round;
  logic        m_ever;
  logic [55:0] m_key;
  logic        m_dec;
  logic        in_dec;

`ifdef DES_DECRYPT_EN
  assign in_dec = bus.decrypt;
`else
  assign in_dec = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_round <= 0;
      m_ever  <= 1'b0;
      m_key   <= '0;
      m_dec   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_key   <= bus.key;
          m_dec   <= in_dec;
          m_round <= 0;
          m_ever  <= 1'b1;
          m_phase <= 1;
        end
        1: if (bus.subkey_ready) begin
          if (m_round == 15) m_phase <= 2;
          else m_round <= m_round + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [47:0] es;
    if (m_phase == 1)
      es = exp_sub(m_key, m_dec, m_round);
    else if (m_ever)
      es = exp_sub(m_key, m_dec, 15);
    else
      es = '0;
    check("subkey_valid", 64'(bus.subkey_valid), 64'(m_phase == 1));
    check("busy", 64'(bus.busy), 64'(m_phase != 0));
    check("done", 64'(bus.done), 64'(m_phase == 2));
    check("subkey", 64'(bus.subkey), 64'(es));
    if (m_phase == 1)
      check("round", 64'(bus.round), 64'(m_round));
  end

  task automatic wait_round(input int r);
    for (int n = 0; n < 200; n++) begin
      if (bus.subkey_valid && bus.round == 4'(r)) return;
      @(negedge clk);
    end
    check("wait_round_timeout", 64'(r), 64'hFFFF);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 400; n++) begin
      if (bus.done) return;
      @(negedge clk);
    end
    check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_dec(input logic d);
`ifdef DES_DECRYPT_EN
    bus.decrypt = d;
`else
    if (d) $display("note: decrypt not built");
`endif
  endtask

  task automatic run_known(input logic d);
    @(negedge clk);
    bus.key          = KREF;
    set_dec(d);
    bus.start        = 1'b1;
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = 56'(~KREF);
    set_dec(~d);
    check("known_r0", 64'(bus.subkey), 64'(d ? K16 : K1));
    wait_round(15);
    check("known_r15", 64'(bus.subkey), 64'(d ? K1 : K16));
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("done_clear", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [55:0] k;
    int          gap;
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.key          = '0;
    bus.subkey_ready = 1'b0;
    set_dec(1'b0);
    #1;
    check("rst_valid", 64'(bus.subkey_valid), 64'd0);
    check("rst_subkey", 64'(bus.subkey), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("model_k1", 64'(exp_sub(KREF, 1'b0, 0)), 64'(K1));
    check("model_k16", 64'(exp_sub(KREF, 1'b0, 15)), 64'(K16));
    check("model_dec0", 64'(exp_sub(KREF, 1'b1, 0)), 64'(K16));

    run_known(1'b0);
`ifdef DES_DECRYPT_EN
    run_known(1'b1);
    set_dec(1'b0);
`endif

    // Stall five cycles in round 3.
    k = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
    @(negedge clk);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_round(3);
    bus.subkey_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_round", 64'(bus.round), 64'd3);
      check("stall_subkey", 64'(bus.subkey), 64'(exp_sub(k, 1'b0, 3)));
    end
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    check("resume_round", 64'(bus.round), 64'd4);
    wait_done();

    // Start with a new key mid-schedule is ignored.
    @(negedge clk);
    bus.key   = KREF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_round(7);
    bus.start = 1'b1;
    bus.key   = k;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_r8", 64'(bus.subkey), 64'(exp_sub(KREF, 1'b0, 8)));
    wait_round(15);
    check("ignore_r15", 64'(bus.subkey), 64'(K16));
    wait_done();

    // Random keys, random ready, spurious starts.
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      bus.key   = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
      set_dec(1'($urandom_range(0, 1)));
      bus.start = 1'b1;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        bus.subkey_ready = 1'($urandom_range(0, 1));
        bus.start        = 1'($urandom_range(0, 3) == 0);
        bus.key          = {$urandom, $urandom} & 56'hFFFFFFFFFFFFFF;
        set_dec(1'($urandom_range(0, 1)));
        if (bus.done) break;
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
    end
    set_dec(1'b0);

    // Asynchronous reset in round 10.
    bus.subkey_ready = 1'b1;
    @(negedge clk);
    bus.key   = KREF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_round(10);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.subkey_valid), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_round", 64'(bus.round), 64'd0);
    check("arst_subkey", 64'(bus.subkey), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_rst_r0", 64'(bus.subkey), 64'(K1));
    wait_done();

    // Start held high: one idle cycle between schedules.
    @(negedge clk);
    bus.start = 1'b1;
    wait_done();
    gap = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      gap++;
      if (bus.subkey_valid) break;
    end
    check("b2b_gap", 64'(gap), 64'd2);
    wait_done();
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/des_key_sched_ctrl.md
DES_KEY_SCHED_CTRL -- requirements
Module: des_key_sched_ctrl

Interface
REQ-001 The module SHALL have exactly one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a new 16-round schedule; sampled only in IDLE.
REQ-005 key  input  56  PC-1-permuted key; C half = key[55:28], D half = key[27:0]; sampled on an accepted start.
REQ-006 decrypt  input  1  schedule order select, sampled with key; present only when DES_DECRYPT_EN is defined.
REQ-007 subkey_ready  input  1  downstream accepts the current subkey.
REQ-008 subkey  output  48  PC-2 (FIPS 46-3) compression of the current C/D registers.
REQ-009 subkey_valid  output  1  subkey and round are valid.
REQ-010 round  output  4  index of the current subkey, 0 to 15.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse after the 16th transfer.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with these transitions:
- IDLE -> RUN on start.
- RUN -> DONE on the round-15 transfer.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 A transfer SHALL occur on any rising edge where subkey_valid and subkey_ready are both high.
REQ-015 On start in IDLE, the C and D registers SHALL load key rotated by the round-0 shift; round SHALL load 0; subkey_valid SHALL go high the next cycle (1-cycle latency).
REQ-016 Encrypt shift SHALL be a left rotation of each 28-bit half by 1 in rounds 0, 1, 8 and 15, and by 2 in all other rounds.
REQ-017 Decrypt shift SHALL be a right rotation of each 28-bit half by 0 in round 0, by 1 in rounds 1, 8 and 15, and by 2 in all other rounds.
REQ-018 On a transfer in rounds 0 to 14, C, D and round SHALL advance to the next round on the same edge, and subkey_valid SHALL stay high; with subkey_ready held high, 16 subkeys SHALL appear on 16 consecutive cycles.
REQ-019 While subkey_valid is high and subkey_ready is low, subkey and round SHALL hold stable with no limit on stall length.
REQ-020 On the round-15 transfer, subkey_valid SHALL drop and done SHALL pulse high in the following cycle (DONE state).
REQ-021 round SHALL NOT wrap; after round 15 the FSM SHALL leave RUN.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 A start in the same cycle as the DONE -> IDLE transition SHALL be ignored; start is accepted only while the FSM is in IDLE.
REQ-024 key and decrypt changes outside an accepted start SHALL have no effect.
REQ-025 subkey SHALL be a combinational function of the C/D registers only.

Reset
REQ-026 rst SHALL immediately force the following, regardless of clk, including mid-schedule:
- state = IDLE
- C = 0, D = 0, round = 0
- subkey_valid = 0, busy = 0, done = 0
- subkey = PC-2 of zero (0x000000000000)
REQ-027 After rst deasserts, the first start SHALL produce a complete, correct schedule.

Configuration
REQ-028 Macro DES_DECRYPT_EN SHALL control decrypt support.
- Defined: the decrypt port exists and REQ-017 applies when decrypt = 1.
- Undefined: the decrypt port is absent and only the encrypt order of REQ-016 is produced.

Verification
REQ-029 Encrypt, key 0xF0CCAAF556678F, start with subkey_ready held at 1 -> round 0 subkey 0x1B02EFFC7072, round 15 subkey 0xCB3D8B0E17F5, done pulses exactly 1 cycle after the round-15 transfer.
REQ-030 DES_DECRYPT_EN defined, same key, decrypt = 1 -> round 0 subkey 0xCB3D8B0E17F5, round 15 subkey 0x1B02EFFC7072.
REQ-031 subkey_ready held at 0 for 5 cycles during round 3 -> subkey and round stay constant; the schedule resumes at round 4 after ready returns to 1.
REQ-032 start pulsed during round 7 with a different key -> no effect; the remaining subkeys match the original key.
REQ-033 rst asserted mid-cycle during round 10 -> all outputs reach reset values before the next clk edge; a new start then yields round 0 subkey 0x1B02EFFC7072.
REQ-034 start held at 1 continuously -> back-to-back schedules, with exactly one IDLE cycle between the DONE cycle and the next RUN.
